// File: rtl/pico.sv
// Shared pico core types: sequencer operation encoding.
package pico;

    typedef enum logic [2:0] {
        INCREMENT = 3'd0,
        RELATIVE  = 3'd1,
        ABSOLUTE  = 3'd2,
        HALT      = 3'd3,
        CALL      = 3'd4,
        RETURN    = 3'd5
    } modeSeq;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: a top pointer plus a saturating count, so overflow
// silently discards the oldest entry and keeps the newest DEPTH addresses.
module pc_ras #(
    parameter int unsigned AW    = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PW   = $clog2(DEPTH),
    localparam int unsigned CW   = PW + 1
) (
    input  logic          clk_i,
    input  logic          n_rst_i,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] wdata,
    output logic [AW-1:0] rdata,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [AW-1:0] mem_q [DEPTH];
    logic [PW-1:0] top_q;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count_q;

    assign wr_ptr = top_q + PW'(1);
    assign full   = (count_q == CW'(DEPTH));
    assign empty  = (count_q == '0);
    assign count  = count_q;
    assign rdata  = mem_q[top_q];

    // Contents are don't-care after reset, so the storage has no reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            top_q   <= '0;
            count_q <= '0;
        end else if (push) begin
            top_q <= wr_ptr;
            if (!full) begin
                count_q <= count_q + CW'(1);
            end
        end else if (pop && !empty) begin
            top_q   <= top_q - PW'(1);
            count_q <= count_q - CW'(1);
        end
    end

endmodule

// File: rtl/pc_seq.sv
// Program counter sequencer with return-address stack and sticky stack-error flags.
// Optional interrupt entry is built when PC_IRQ_EN is defined.
module pc_seq
    import pico::*;
#(
    parameter int unsigned AW      = 8,
    parameter int unsigned DW      = 8,
    parameter int unsigned DEPTH   = 4,
    parameter logic [AW-1:0] IRQ_VEC = AW'(1),
    localparam int unsigned CW     = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          n_rst_i,
    input  logic          en_i,
    input  modeSeq        mode_i,
    input  logic [DW-1:0] data_i,
    input  logic          clr_err_i,
    output logic [AW-1:0] addr_o,
    output logic [CW-1:0] depth_o,
    output logic          ovf_o,
    output logic          unf_o
`ifdef PC_IRQ_EN
    ,
    input  logic          irq_i,
    output logic          irq_ack_o
`endif
);

    logic [AW-1:0] addr_q, addr_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          ovf_ev, unf_ev;
    logic          irq_take;

    logic          push, pop;
    logic [AW-1:0] wdata, rdata;
    logic          full, empty;
    logic [AW-1:0] data_ext;

    assign data_ext = AW'($signed(data_i));

`ifdef PC_IRQ_EN
    logic irq_ack_q;
    assign irq_take  = en_i & irq_i;
    assign irq_ack_o = irq_ack_q;
`else
    assign irq_take  = 1'b0;
`endif

    always_comb begin
        addr_d = addr_q;
        push   = 1'b0;
        pop    = 1'b0;
        wdata  = addr_q + AW'(1);
        ovf_ev = 1'b0;
        unf_ev = 1'b0;
        if (irq_take) begin
            // Save the un-executed instruction so RETURN re-runs it.
            push   = 1'b1;
            wdata  = addr_q;
            addr_d = IRQ_VEC;
            ovf_ev = full;
        end else if (en_i) begin
            case (mode_i)
                INCREMENT: addr_d = addr_q + AW'(1);
                RELATIVE:  addr_d = addr_q + data_ext;
                ABSOLUTE:  addr_d = data_ext;
                CALL: begin
                    push   = 1'b1;
                    addr_d = data_ext;
                    ovf_ev = full;
                end
                RETURN: begin
                    if (empty) begin
                        unf_ev = 1'b1;
                    end else begin
                        pop    = 1'b1;
                        addr_d = rdata;
                    end
                end
                default: addr_d = addr_q;
            endcase
        end
    end

    // Error events take priority over a same-cycle clear.
    always_comb begin
        ovf_d = ovf_ev ? 1'b1 : (clr_err_i ? 1'b0 : ovf_q);
        unf_d = unf_ev ? 1'b1 : (clr_err_i ? 1'b0 : unf_q);
    end

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            addr_q <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            addr_q <= addr_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
        end
    end

`ifdef PC_IRQ_EN
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            irq_ack_q <= 1'b0;
        end else begin
            irq_ack_q <= irq_take;
        end
    end
`endif

    pc_ras #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_ras (
        .clk_i   (clk_i),
        .n_rst_i (n_rst_i),
        .push    (push),
        .pop     (pop),
        .wdata   (wdata),
        .rdata   (rdata),
        .count   (depth_o),
        .full    (full),
        .empty   (empty)
    );

    assign addr_o = addr_q;
    assign ovf_o  = ovf_q;
    assign unf_o  = unf_q;

endmodule

// File: tb/tb_pc_seq.sv
// Directed bench for pc_seq (AW=8, DW=8, DEPTH=4); expected outputs queued per step.
module tb_pc_seq;
    import pico::*;

    logic       clk_i = 1'b0;
    logic       n_rst_i;
    logic       en_i;
    modeSeq     mode_i;
    logic [7:0] data_i;
    logic       clr_err_i;
    logic [7:0] addr_o;
    logic [2:0] depth_o;
    logic       ovf_o;
    logic       unf_o;
    logic       irq_i = 1'b0;
    logic       irq_ack_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] addr;
        logic [2:0] depth;
        logic       ovf;
        logic       unf;
        logic       ack;
    } exp_t;

    exp_t sb[$];

    always #5 clk_i = ~clk_i;

    pc_seq #(
        .AW      (8),
        .DW      (8),
        .DEPTH   (4),
        .IRQ_VEC (8'h01)
    ) dut (
        .clk_i     (clk_i),
        .n_rst_i   (n_rst_i),
        .en_i      (en_i),
        .mode_i    (mode_i),
        .data_i    (data_i),
        .clr_err_i (clr_err_i),
        .addr_o    (addr_o),
        .depth_o   (depth_o),
        .ovf_o     (ovf_o),
        .unf_o     (unf_o)
`ifdef PC_IRQ_EN
        ,
        .irq_i     (irq_i),
        .irq_ack_o (irq_ack_o)
`endif
    );

`ifndef PC_IRQ_EN
    assign irq_ack_o = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic compare_out(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: scoreboard empty, observed addr %0h expected an entry", tag, addr_o);
        end else begin
            e = sb.pop_front();
            check({tag, ".addr"}, 32'(addr_o), 32'(e.addr));
            check({tag, ".depth"}, 32'(depth_o), 32'(e.depth));
            check({tag, ".ovf"}, 32'(ovf_o), 32'(e.ovf));
            check({tag, ".unf"}, 32'(unf_o), 32'(e.unf));
            check({tag, ".ack"}, 32'(irq_ack_o), 32'(e.ack));
        end
    endtask

    // Drive one cycle of stimulus, queue its expected result, compare #1 after the edge.
    task automatic step(input string tag, input logic en, input modeSeq m, input logic [7:0] d,
                        input logic clr, input logic irq,
                        input logic [7:0] ea, input logic [2:0] ed, input logic eo,
                        input logic eu, input logic eack);
        exp_t e;
        en_i = en; mode_i = m; data_i = d; clr_err_i = clr; irq_i = irq;
        e.addr = ea; e.depth = ed; e.ovf = eo; e.unf = eu; e.ack = eack;
        sb.push_back(e);
        @(posedge clk_i);
        #1;
        compare_out(tag);
    endtask

    initial begin
        n_rst_i = 1'b0; en_i = 1'b0; mode_i = HALT; data_i = '0; clr_err_i = 1'b0;
        #12;
        sb.push_back('{addr: 8'h00, depth: 3'd0, ovf: 1'b0, unf: 1'b0, ack: 1'b0});
        compare_out("reset");
        @(negedge clk_i);
        n_rst_i = 1'b1;
        @(posedge clk_i);
        #1;

        step("inc1", 1, INCREMENT, 8'h00, 0, 0, 8'h01, 3'd0, 0, 0, 0);
        step("inc2", 1, INCREMENT, 8'h00, 0, 0, 8'h02, 3'd0, 0, 0, 0);
        step("inc3", 1, INCREMENT, 8'h00, 0, 0, 8'h03, 3'd0, 0, 0, 0);
        step("absFE", 1, ABSOLUTE, 8'hFE, 0, 0, 8'hFE, 3'd0, 0, 0, 0);
        step("incFF", 1, INCREMENT, 8'h00, 0, 0, 8'hFF, 3'd0, 0, 0, 0);
        step("incwrap", 1, INCREMENT, 8'h00, 0, 0, 8'h00, 3'd0, 0, 0, 0);
        step("relneg1", 1, RELATIVE, 8'hFF, 0, 0, 8'hFF, 3'd0, 0, 0, 0);
        step("abs10", 1, ABSOLUTE, 8'h10, 0, 0, 8'h10, 3'd0, 0, 0, 0);
        step("relm3", 1, RELATIVE, 8'hFD, 0, 0, 8'h0D, 3'd0, 0, 0, 0);
        step("abs40", 1, ABSOLUTE, 8'h40, 0, 0, 8'h40, 3'd0, 0, 0, 0);
        step("stall_inc", 0, INCREMENT, 8'h00, 0, 1, 8'h40, 3'd0, 0, 0, 0);
        step("stall_call", 0, CALL, 8'h77, 0, 0, 8'h40, 3'd0, 0, 0, 0);
        step("halt", 1, HALT, 8'h12, 0, 0, 8'h40, 3'd0, 0, 0, 0);
        step("illegal", 1, modeSeq'(3'd7), 8'h12, 0, 0, 8'h40, 3'd0, 0, 0, 0);

        step("abs05", 1, ABSOLUTE, 8'h05, 0, 0, 8'h05, 3'd0, 0, 0, 0);
        step("call20", 1, CALL, 8'h20, 0, 0, 8'h20, 3'd1, 0, 0, 0);
        step("ret06", 1, RETURN, 8'h00, 0, 0, 8'h06, 3'd0, 0, 0, 0);

        step("abs00", 1, ABSOLUTE, 8'h00, 0, 0, 8'h00, 3'd0, 0, 0, 0);
        step("call_a", 1, CALL, 8'h10, 0, 0, 8'h10, 3'd1, 0, 0, 0);
        step("call_b", 1, CALL, 8'h20, 0, 0, 8'h20, 3'd2, 0, 0, 0);
        step("call_c", 1, CALL, 8'h30, 0, 0, 8'h30, 3'd3, 0, 0, 0);
        step("call_d", 1, CALL, 8'h40, 0, 0, 8'h40, 3'd4, 0, 0, 0);
        step("call_ovf", 1, CALL, 8'h50, 0, 0, 8'h50, 3'd4, 1, 0, 0);
        step("ret41", 1, RETURN, 8'h00, 0, 0, 8'h41, 3'd3, 1, 0, 0);
        step("ret31", 1, RETURN, 8'h00, 0, 0, 8'h31, 3'd2, 1, 0, 0);
        step("ret21", 1, RETURN, 8'h00, 0, 0, 8'h21, 3'd1, 1, 0, 0);
        step("ret11", 1, RETURN, 8'h00, 0, 0, 8'h11, 3'd0, 1, 0, 0);
        step("ret_unf", 1, RETURN, 8'h00, 0, 0, 8'h11, 3'd0, 1, 1, 0);
        step("clr_both", 1, HALT, 8'h00, 1, 0, 8'h11, 3'd0, 0, 0, 0);

        step("unf_wins", 1, RETURN, 8'h00, 1, 0, 8'h11, 3'd0, 0, 1, 0);
        step("unf_clr", 1, HALT, 8'h00, 1, 0, 8'h11, 3'd0, 0, 0, 0);
        step("unf_again", 1, RETURN, 8'h00, 0, 0, 8'h11, 3'd0, 0, 1, 0);
        step("clr_stalled", 0, RETURN, 8'h00, 1, 0, 8'h11, 3'd0, 0, 0, 0);

`ifdef PC_IRQ_EN
        step("abs33", 1, ABSOLUTE, 8'h33, 0, 0, 8'h33, 3'd0, 0, 0, 0);
        step("irq", 1, ABSOLUTE, 8'h50, 0, 1, 8'h01, 3'd1, 0, 0, 1);
        step("irq_ret", 1, RETURN, 8'h00, 0, 0, 8'h33, 3'd0, 0, 0, 0);
`endif

        // Build non-reset state, then assert reset between edges.
        step("pre_rst_call", 1, CALL, 8'h66, 0, 0, 8'h66, 3'd1, 0, 0, 0);
        step("pre_rst_unf", 1, HALT, 8'h00, 0, 0, 8'h66, 3'd1, 0, 0, 0);
        en_i = 1'b0;
        #2;
        n_rst_i = 1'b0;
        #1;
        sb.push_back('{addr: 8'h00, depth: 3'd0, ovf: 1'b0, unf: 1'b0, ack: 1'b0});
        compare_out("async_rst");
        @(negedge clk_i);
        n_rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        step("post_rst_inc", 1, INCREMENT, 8'h00, 0, 0, 8'h01, 3'd0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
